mul_arbiter: RTL and testbench

- Shares one CompMultiplier instance between N_REQ requesters.
- Arbitrates the requesters round-robin and latches the winner's operands.
- Sequences the multiplier's Reset/Run/Ready protocol, then returns the 64-bit product to the winner with a one-cycle done pulse.
- Sits between the CPU-side multiply clients and the multiplier datapath; includes a watchdog for a hung Ready.

---
 rtl/mul_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/mul_arbiter.sv | 146 ++++++++++++++
 tb/tb_mul_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter.
package mul_arb_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 128;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GAP,
        RUN,
        DONE,
        ABORT
    } state_t;

    // Width able to index 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W:0]   idx;
    logic [IDX_W-1:0] idx_n;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        idx_n  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            // Scan order ptr, ptr+1, ... wrapping at N_REQ.
            idx = {1'b0, ptr} + (IDX_W+1)'(off);
            if (idx >= (IDX_W+1)'(N_REQ)) begin
                idx = idx - (IDX_W+1)'(N_REQ);
            end
            idx_n = idx[IDX_W-1:0];
            if (!valid && req[idx_n]) begin
                valid        = 1'b1;
                winner       = idx_n;
                grant[idx_n] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between N_REQ requesters: round-robin grant, Reset/Run/Ready
// sequencing, product return with a done pulse, and a Ready watchdog.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_multiplicand,
    input  logic [N_REQ*DATA_W-1:0] req_multiplier,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [2*DATA_W-1:0]     result,
    output logic                    busy,
    output logic [DATA_W-1:0]       mul_Multiplicand_in,
    output logic [DATA_W-1:0]       mul_Multiplier_in,
    output logic                    mul_Reset,
    output logic                    mul_Run,
    input  logic                    mul_Ready,
    input  logic [2*DATA_W-1:0]     mul_Product_out
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = idx_width(TIMEOUT_CYC);

    state_t               state_reg,  state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [N_REQ-1:0]     grant_reg,  grant_next;
    logic [DATA_W-1:0]    mcand_reg,  mcand_next;
    logic [DATA_W-1:0]    mplier_reg, mplier_next;
    logic [2*DATA_W-1:0]  result_reg, result_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;
    logic                 ready_q_reg;

    logic [DATA_W-1:0]    mcand_arr  [N_REQ];
    logic [DATA_W-1:0]    mplier_arr [N_REQ];
    logic [N_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]     arb_winner;
    logic                 arb_valid;
    logic                 ready_edge;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign mcand_arr[gi]  = req_multiplicand[gi*DATA_W +: DATA_W];
        assign mplier_arr[gi] = req_multiplier[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .grant  (arb_grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // A Ready still high from the previous operation must not count as completion.
    assign ready_edge = mul_Ready && !ready_q_reg;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            grant_reg   <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            ready_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            grant_reg   <= grant_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            result_reg  <= result_next;
            cnt_reg     <= cnt_next;
            ready_q_reg <= mul_Ready;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        result_next = result_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next  = CLEAR;
                    grant_next  = arb_grant;
                    mcand_next  = mcand_arr[arb_winner];
                    mplier_next = mplier_arr[arb_winner];
                    rr_ptr_next = (arb_winner == IDX_W'(N_REQ-1)) ? '0
                                                                  : arb_winner + IDX_W'(1);
                end
            end
            CLEAR: begin
                state_next = GAP;
            end
            GAP: begin
                state_next = RUN;
                cnt_next   = '0;
            end
            RUN: begin
                // The Ready edge takes priority over a simultaneous terminal count.
                if (ready_edge) begin
                    result_next = mul_Product_out;
                    state_next  = DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC-1)) begin
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE, ABORT: begin
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant               = grant_reg;
    assign done                = (state_reg == DONE)  ? grant_reg : '0;
    assign err                 = (state_reg == ABORT) ? grant_reg : '0;
    assign result              = result_reg;
    assign busy                = (state_reg != IDLE);
    assign mul_Reset           = (state_reg == CLEAR);
    assign mul_Run             = (state_reg == RUN);
    assign mul_Multiplicand_in = mcand_reg;
    assign mul_Multiplier_in   = mplier_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a small behavioural multiplier model.
module tb_mul_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int LAT    = 4;

    logic                    clk;
    logic                    Reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_multiplicand;
    logic [N_REQ*DATA_W-1:0] req_multiplier;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic [2*DATA_W-1:0]     result;
    logic                    busy;
    logic [DATA_W-1:0]       mul_Multiplicand_in;
    logic [DATA_W-1:0]       mul_Multiplier_in;
    logic                    mul_Reset;
    logic                    mul_Run;
    logic                    mul_Ready;
    logic [2*DATA_W-1:0]     mul_Product_out;

    int checks;
    int failures;

    logic mdl_hold;
    logic mdl_never;
    logic mdl_drop;
    int   mdl_cnt;

    mul_arbiter #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (128)
    ) dut (
        .clk                 (clk),
        .Reset               (Reset),
        .req                 (req),
        .req_multiplicand    (req_multiplicand),
        .req_multiplier      (req_multiplier),
        .grant               (grant),
        .done                (done),
        .err                 (err),
        .result              (result),
        .busy                (busy),
        .mul_Multiplicand_in (mul_Multiplicand_in),
        .mul_Multiplier_in   (mul_Multiplier_in),
        .mul_Reset           (mul_Reset),
        .mul_Run             (mul_Run),
        .mul_Ready           (mul_Ready),
        .mul_Product_out     (mul_Product_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: Ready rises LAT cycles into Run; mul_Reset clears it unless held.
    always @(posedge clk) begin
        if (Reset) begin
            mul_Ready       <= 1'b0;
            mul_Product_out <= '0;
            mdl_cnt         <= 0;
        end else if (mdl_drop) begin
            mul_Ready <= 1'b0;
            mdl_cnt   <= 0;
        end else if (mul_Reset && !mdl_hold) begin
            mul_Ready <= 1'b0;
            mdl_cnt   <= 0;
        end else if (mul_Run && !mul_Ready && !mdl_never) begin
            if (mdl_cnt == LAT-1) begin
                mul_Ready       <= 1'b1;
                mul_Product_out <= {32'h0, mul_Multiplicand_in} * {32'h0, mul_Multiplier_in};
                mdl_cnt         <= 0;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic set_ops(input int slot, input logic [31:0] a, input logic [31:0] b);
        req_multiplicand[slot*DATA_W +: DATA_W] = a;
        req_multiplier[slot*DATA_W +: DATA_W]   = b;
    endtask

    task automatic wait_run(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mul_Run) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Steps until done or err pulses; all outputs zero if the bound expires.
    task automatic wait_evt(input int max_cyc, output int n, output logic [3:0] d,
                            output logic [3:0] e, output logic [63:0] r, output logic [3:0] g);
        n = 0; d = '0; e = '0; r = '0; g = '0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if ((done | err) != '0) begin
                d = done; e = err; r = result; g = grant;
                return;
            end
        end
    endtask

    int          n;
    int          pulses;
    logic [3:0]  d, e, g;
    logic [63:0] r;
    logic        ok;
    logic [3:0]  rr_grant [5];
    logic [63:0] rr_res   [5];

    initial begin
        checks = 0; failures = 0;
        mdl_hold = 1'b0; mdl_never = 1'b0; mdl_drop = 1'b0;
        Reset = 1'b1; req = '0;
        req_multiplicand = '0; req_multiplier = '0;
        rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_res   = '{64'h3F, 64'h1_0000_0000, 64'h1_FFFF_FFFE, 64'hFFFF_FFFE_0000_0001, 64'h3F};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_result", result, 0);
        check("rst_mul_ctl", {mul_Reset, mul_Run}, 0);
        Reset = 1'b0;

        // Single request 3*5
        set_ops(0, 32'd3, 32'd5);
        req = 4'b0001;
        @(negedge clk);
        check("single_clear", {mul_Reset, mul_Run, busy}, 3'b101);
        check("single_grant", grant, 4'b0001);
        check("single_ops", {mul_Multiplicand_in, mul_Multiplier_in}, {32'd3, 32'd5});
        @(negedge clk);
        check("single_gap", {mul_Reset, mul_Run}, 2'b00);
        @(negedge clk);
        check("single_run", {mul_Reset, mul_Run}, 2'b01);
        wait_evt(40, n, d, e, r, g);
        check("single_latency", 3 + n, 8);
        check("single_done", d, 4'b0001);
        check("single_result", r, 64'hF);
        req = '0;
        @(negedge clk);
        check("single_after", {busy, grant, done}, 0);

        // Round-robin after a fresh reset
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        set_ops(0, 32'd7, 32'd9);
        set_ops(1, 32'h0001_0000, 32'h0001_0000);
        set_ops(2, 32'hFFFF_FFFF, 32'h2);
        set_ops(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_evt(40, n, d, e, r, g);
            check($sformatf("rr%0d_done", k), d, rr_grant[k]);
            check($sformatf("rr%0d_result", k), r, rr_res[k]);
        end
        req = '0;

        // Stale Ready: op A completes, Ready held high into op B
        set_ops(0, 32'd2, 32'd3);
        req = 4'b0001;
        wait_evt(40, n, d, e, r, g);
        check("staleA_done", d, 4'b0001);
        check("staleA_result", r, 64'h6);
        mdl_hold = 1'b1;
        set_ops(1, 32'd4, 32'd5);
        req = 4'b0010;
        wait_run(10, ok);
        check("staleB_run", ok, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((done | err) != '0) pulses++;
        end
        check("staleB_no_done", pulses, 0);
        check("staleB_ready_high", {mul_Ready, mul_Run}, 2'b11);
        mdl_drop = 1'b1;
        @(negedge clk);
        mdl_drop = 1'b0;
        mdl_hold = 1'b0;
        wait_evt(30, n, d, e, r, g);
        check("staleB_done", d, 4'b0010);
        check("staleB_result", r, 64'h14);
        req = '0;

        // Timeout: Ready never rises
        mdl_never = 1'b1;
        set_ops(2, 32'd9, 32'd9);
        req = 4'b0100;
        wait_run(10, ok);
        check("to_run", ok, 1);
        wait_evt(200, n, d, e, r, g);
        check("to_cycles", n, 128);
        check("to_err_done", {e, d}, {4'b0100, 4'b0000});
        check("to_result_kept", r, 64'h14);
        req = '0;
        mdl_never = 1'b0;
        @(negedge clk);
        check("to_after", {busy, err}, 0);
        set_ops(3, 32'd6, 32'd7);
        req = 4'b1000;
        wait_evt(40, n, d, e, r, g);
        check("to_next_done", d, 4'b1000);
        check("to_next_result", r, 64'h2A);
        req = '0;

        // Mid-op reset; rr_ptr would be 2 without it
        req = 4'b0010;
        wait_run(10, ok);
        check("mid_run", ok, 1);
        Reset = 1'b1;
        #1;
        check("mid_async", {grant, mul_Run, busy}, 0);
        req = '0;
        @(negedge clk);
        Reset = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        check("mid_ptr0_grant", grant, 4'b0001);
        wait_evt(40, n, d, e, r, g);
        check("mid_ptr0_done", d, 4'b0001);
        check("mid_ptr0_result", r, 64'h6);
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check("mid_req3_clear", {mul_Reset, grant}, {1'b1, 4'b1000});
        wait_evt(40, n, d, e, r, g);
        check("mid_req3_done", d, 4'b1000);
        check("mid_req3_result", r, 64'h2A);
        req = '0;

        // Dropped request with operand change in flight
        set_ops(1, 32'h1234, 32'h10);
        req = 4'b0010;
        wait_run(10, ok);
        check("drop_run", ok, 1);
        req = '0;
        set_ops(1, 32'hDEAD, 32'hBEEF);
        wait_evt(40, n, d, e, r, g);
        check("drop_done", d, 4'b0010);
        check("drop_result", r, 64'h12340);
        @(negedge clk);
        req = 4'b0101;
        @(negedge clk);
        check("drop_ptr2_grant", grant, 4'b0100);
        wait_evt(40, n, d, e, r, g);
        check("drop_ptr2_done", d, 4'b0100);
        check("drop_ptr2_result", r, 64'h51);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
